// File: rtl/stream_mux_rr_if.sv
// Bundle of the N-to-1 mux handshake: NCH input channels plus mode/select, one output stream.
// The mux takes the slave view; the producer/consumer side (or a bench) takes the master view.
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux, fixed-select or round-robin, one registered output stage (1-cycle latency).
// While the output register is stalled every in_ready is 0; ungranted channels are simply held off.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  stream_mux_rr_if.slave bus
);
  localparam int NPAD = 1 << SELW;

  // Channels padded to a power of two; pad slots are never valid, so an out-of-range sel yields no grant.
  logic [WIDTH-1:0] ch_dat [NPAD];
  logic [NPAD-1:0]  ch_vld;

  for (genvar i = 0; i < NPAD; i++) begin : g_pad
    if (i < NCH) begin : g_real
      assign ch_dat[i] = bus.in_data[i*WIDTH +: WIDTH];
      assign ch_vld[i] = bus.in_valid[i];
    end else begin : g_none
      assign ch_dat[i] = '0;
      assign ch_vld[i] = 1'b0;
    end
  end

  logic [SELW-1:0]  last_q, last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  gnt, scan_idx;
  logic             gnt_vld, load;
  logic [NCH-1:0]   in_ready;

  always_comb begin
    load     = !out_valid_q || bus.out_ready;
    gnt_vld  = 1'b0;
    gnt      = '0;
    scan_idx = '0;
    if (!bus.mode) begin
      gnt_vld = ch_vld[bus.sel];
      gnt     = bus.sel;
    end else begin
      // Scan farthest-first so the nearest valid channel after last_q is the one left standing.
      for (int k = NCH; k >= 1; k--) begin
        scan_idx = SELW'((int'(last_q) + k) % NCH);
        if (ch_vld[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt     = scan_idx;
        end
      end
    end

    in_ready = '0;
    if (!rst && load && gnt_vld) in_ready[gnt] = 1'b1;

    last_d      = last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = ch_dat[gnt];
        out_ch_d   = gnt;
        last_d     = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= SELW'(NCH - 1);
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule
